// File: rtl/uart_tx_cfg.sv
// Parameterised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity and STOP_BITS stop bits, each CLK_PER_BIT clocks long.
module uart_tx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int CLK_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 serial
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLK_PER_BIT < 2) begin : g_bad_clk_per_bit
        $error("uart_tx_cfg: CLK_PER_BIT must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_par, w_par_nxt;
    logic                 r_serial, w_serial_nxt;
    logic                 r_done, w_done_nxt;
    logic                 w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_serial <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_serial <= w_serial_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // serial is registered, so each branch computes the level for the next bit
    // at the edge that closes the current one.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = w_bit_end ? '0 : r_cnt + CNT_W'(1);
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_par_nxt    = r_par;
        w_serial_nxt = r_serial;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt    = '0;
                w_idx_nxt    = '0;
                w_serial_nxt = 1'b1;
                if (valid) begin
                    w_shift_nxt  = data;
                    w_par_nxt    = (PARITY == 1) ? ~(^data) : (^data);
                    w_state_nxt  = S_START;
                    w_serial_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt  = S_DATA;
                    w_serial_nxt = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == DATA_LAST) begin
                        w_idx_nxt = '0;
                        if (PARITY != 0) begin
                            w_state_nxt  = S_PARITY;
                            w_serial_nxt = r_par;
                        end else begin
                            w_state_nxt  = S_STOP;
                            w_serial_nxt = 1'b1;
                        end
                    end else begin
                        w_idx_nxt    = r_idx + IDX_W'(1);
                        w_shift_nxt  = r_shift >> 1;
                        w_serial_nxt = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt  = S_STOP;
                    w_serial_nxt = 1'b1;
                end
            end
            S_STOP: begin
                w_serial_nxt = 1'b1;
                if (w_bit_end) begin
                    if (r_idx == STOP_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_cnt_nxt    = '0;
                w_idx_nxt    = '0;
                w_serial_nxt = 1'b1;
            end
        endcase
    end

    assign ready  = (r_state == S_IDLE);
    assign busy   = ~ready;
    assign done   = r_done;
    assign serial = r_serial;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Random and directed frames on several UART configurations, each checked
// cycle by cycle against a bit-list model of the frame.
module tb_uart_tx_cfg;

    localparam int NDUT = 5;

    function automatic int cdb(input int k);
        case (k)
            0: return 8;
            1: return 8;
            2: return 7;
            3: return 9;
            default: return 5;
        endcase
    endfunction
    function automatic int cpar(input int k);
        case (k)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int csb(input int k);
        case (k)
            1: return 2;
            3: return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int ccpb(input int k);
        case (k)
            2: return 3;
            3: return 2;
            4: return 5;
            default: return 4;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] data   [NDUT];
    logic       valid  [NDUT];
    logic       ready  [NDUT];
    logic       busy   [NDUT];
    logic       done   [NDUT];
    logic       serial [NDUT];

    int n_chk  = 0;
    int n_fail = 0;
    bit exp_bits[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int DB = cdb(g);
        uart_tx_cfg #(
            .DATA_BITS  (DB),
            .PARITY     (cpar(g)),
            .STOP_BITS  (csb(g)),
            .CLK_PER_BIT(ccpb(g))
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .data  (data[g][DB-1:0]),
            .valid (valid[g]),
            .ready (ready[g]),
            .busy  (busy[g]),
            .done  (done[g]),
            .serial(serial[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Line level per bit-time: start, data LSB first, parity, stop bits.
    task automatic build(input int k, input logic [8:0] v);
        int ones;
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < cdb(k); i++) begin
            exp_bits.push_back(v[i]);
            ones += int'(v[i]);
        end
        if (cpar(k) == 2) exp_bits.push_back(ones % 2 == 1);
        else if (cpar(k) == 1) exp_bits.push_back(ones % 2 == 0);
        for (int i = 0; i < csb(k); i++) exp_bits.push_back(1'b1);
    endtask

    // Called at a negedge where DUT k is idle; returns at the negedge of its done cycle.
    task automatic frame(input int k, input logic [8:0] v, input bit noise);
        int nb;
        build(k, v);
        nb = exp_bits.size();
        chk($sformatf("ready_pre[%0d]", k), 32'(ready[k]), 1);
        data[k]  = v;
        valid[k] = 1'b1;
        for (int c = 0; c < nb * ccpb(k); c++) begin
            @(negedge clk);
            if (noise) begin
                valid[k] = 1'($urandom);
                data[k]  = ($urandom_range(0, 1) == 1) ? 9'h1FF : 9'($urandom);
            end else begin
                valid[k] = 1'b0;
            end
            chk($sformatf("serial[%0d] v=%0h c=%0d", k, v, c), 32'(serial[k]),
                32'(exp_bits[c / ccpb(k)]));
            chk($sformatf("busy[%0d] c=%0d", k, c), 32'(busy[k]), 1);
            chk($sformatf("done_lo[%0d] c=%0d", k, c), 32'(done[k]), 0);
        end
        @(negedge clk);
        valid[k] = 1'b0;
        chk($sformatf("done[%0d] v=%0h", k, v), 32'(done[k]), 1);
        chk($sformatf("ready_post[%0d]", k), 32'(ready[k]), 1);
        chk($sformatf("serial_done[%0d]", k), 32'(serial[k]), 1);
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) begin
            @(negedge clk);
            chk($sformatf("idle_done[%0d]", k), 32'(done[k]), 0);
            chk($sformatf("idle_serial[%0d]", k), 32'(serial[k]), 1);
            chk($sformatf("idle_ready[%0d]", k), 32'(ready[k]), 1);
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            valid[k] = 1'b0;
            data[k]  = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("rst_ready[%0d]", k), 32'(ready[k]), 1);
            chk($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 0);
            chk($sformatf("rst_done[%0d]", k), 32'(done[k]), 0);
            chk($sformatf("rst_serial[%0d]", k), 32'(serial[k]), 1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        frame(0, 9'h0A5, 1'b0); idle(0, 3);
        frame(1, 9'h000, 1'b0); idle(1, 3);
        frame(2, 9'h041, 1'b0); idle(2, 2);
        frame(4, 9'h041, 1'b0); idle(4, 2);

        // held valid: second accept lands in the done cycle
        frame(0, 9'h055, 1'b0);
        frame(0, 9'h0AA, 1'b0);
        idle(0, 2);

        frame(0, 9'h000, 1'b1); idle(0, 2);

        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 8; i++) begin
                frame(k, 9'($urandom), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) idle(k, $urandom_range(1, 4));
            end
            idle(k, 1);
        end

        // abort during data bit 3 (cycles 16..19 of the frame)
        data[0]  = 9'h0C3;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_bit3", 32'(serial[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_serial", 32'(serial[0]), 1);
        chk("abort_ready", 32'(ready[0]), 1);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_done", 32'(done[0]), 0);
        @(negedge clk);
        chk("abort_done_hold", 32'(done[0]), 0);
        rst_n = 1'b1;
        frame(0, 9'h03C, 1'b0);
        idle(0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
